// File: rtl/booth_mult_sequencer_pkg.sv
// mult_pkg: shared types and sizing helpers
// for the radix-4 Booth multiplier slice.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD_M,
    OP_ADD_2M,
    OP_SUB_M,
    OP_SUB_2M
  } booth_op_t;

  localparam int DEF_WIDTH = 32;
  localparam int P_WIDTH   = 2*DEF_WIDTH+3;

  function automatic int iters(input int width);
    return width/2;
  endfunction

  function automatic int p_width(input int width);
    return 2*width+3;
  endfunction

endpackage

// File: rtl/booth_mult_sequencer_if.sv
// Start/operand/result bundle between the
// execute stage and the Booth multiplier.
interface booth_mult_sequencer_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
);

  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_MULT,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/booth_recode4.sv
// booth_recode4: maps {q1,q0,q_m1} to the
// radix-4 Booth partial-product operation.
module booth_recode4
  import mult_pkg::*;
(
  input  logic [2:0] bits,
  output booth_op_t  op
);

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      (bits == 3'b001) || (bits == 3'b010):
        op = OP_ADD_M;
      (bits == 3'b011):
        op = OP_ADD_2M;
      (bits == 3'b100):
        op = OP_SUB_2M;
      (bits == 3'b101) || (bits == 3'b110):
        op = OP_SUB_M;
      default:
        op = OP_NONE;
    endcase
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer: iterative radix-4 Booth multiplier.
// `define MULT_ZERO_BYPASS_EN skips iterations on zero operands.
module booth_mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clock,
  input logic reset,
  booth_mult_sequencer_if.slave bus
);

  localparam int ITERS = iters(WIDTH);
  localparam int PW    = p_width(WIDTH);
  localparam int CW    = $clog2(ITERS)+1;
  localparam int AW    = WIDTH+2;

  state_t           state;
  logic [AW-1:0]    m;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  booth_op_t        op;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [PW-1:0]    p_shift;
  logic [AW-1:0]    acc_n;
  logic [WIDTH-1:0] q_n;
  logic             qm1_n;
  logic [AW-1:0]    ext_a;
  logic             zero_op;
  logic             last;

  booth_recode4 u_recode (
    .bits ({q[1:0], q_m1}),
    .op   (op)
  );

  always_comb begin
    addend = '0;
    unique case (op)
      OP_ADD_M:  addend = m;
      OP_ADD_2M: addend = {m[AW-2:0], 1'b0};
      OP_SUB_M:  addend = -m;
      OP_SUB_2M: addend = -{m[AW-2:0], 1'b0};
      default:   addend = '0;
    endcase
  end

  // Add, then shift the whole product register with sign fill.
  assign sum     = acc + addend;
  assign p_shift = $signed({sum, q, q_m1}) >>> 2;
  assign acc_n   = p_shift[PW-1 -: AW];
  assign q_n     = p_shift[WIDTH:1];
  assign qm1_n   = p_shift[0];

  assign ext_a = {{2{bus.data_operandA[WIDTH-1]}},
                  bus.data_operandA};
  assign last  = (count == CW'(ITERS-1));

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (bus.data_operandA == '0) ||
                   (bus.data_operandB == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      count    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      m     <= ext_a;
      acc   <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      if (zero_op) begin
        q        <= '0;
        state    <= DONE;
        result_q <= '0;
        exc_q    <= 1'b0;
      end else begin
        q     <= bus.data_operandB;
        state <= RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          acc   <= acc_n;
          q     <= q_n;
          q_m1  <= qm1_n;
          count <= count + 1'b1;
          if (last) begin
            state    <= DONE;
            result_q <= q_n;
            exc_q    <= acc_n !=
                        {AW{q_n[WIDTH-1]}};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state == RUN);

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// tb_booth_mult_sequencer: directed vectors for
// the radix-4 Booth multiplier (WIDTH=32).
module tb_booth_mult_sequencer;

`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 16;
`endif

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   lat;
  int   busy_n;
  logic seen;

  booth_mult_sequencer_if #(.WIDTH(32)) bus ();

  booth_mult_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
  endtask

  task automatic wait_rdy(output int n,
                          output int nb);
    n  = 0;
    nb = 0;
    while (!bus.data_resultRDY && n < 100) begin
      if (bus.busy) nb++;
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] er,
                     input logic ee,
                     input int el);
    int n;
    int nb;
    start(a, b);
    wait_rdy(n, nb);
    check({tag, "_lat"}, 64'(n), 64'(el));
    check({tag, "_res"},
          64'(bus.data_result), 64'(er));
    check({tag, "_exc"},
          64'(bus.data_exception), 64'(ee));
    @(posedge clock);
    #1;
    check({tag, "_rdy_pulse"},
          64'(bus.data_resultRDY), 64'd0);
    check({tag, "_hold"},
          64'(bus.data_result), 64'(er));
  endtask

  initial begin
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdy",
          64'(bus.data_resultRDY), 64'd0);
    check("rst_res",
          64'(bus.data_result), 64'd0);
    check("rst_exc",
          64'(bus.data_exception), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    start(32'd7, 32'hFFFF_FFFD);
    wait_rdy(lat, busy_n);
    check("7x-3_lat", 64'(lat), 64'd16);
    check("7x-3_busy", 64'(busy_n), 64'd16);
    check("7x-3_res", 64'(bus.data_result),
          64'h0000_0000_FFFF_FFEB);
    check("7x-3_exc",
          64'(bus.data_exception), 64'd0);
    check("7x-3_nobusy", 64'(bus.busy), 64'd0);
    @(posedge clock);
    #1;
    check("7x-3_rdy_pulse",
          64'(bus.data_resultRDY), 64'd0);

    run("2^16sq", 32'h0001_0000, 32'h0001_0000,
        32'h0000_0000, 1'b1, 16);
    run("min_x1", 32'h8000_0000, 32'd1,
        32'h8000_0000, 1'b0, 16);
    run("min_xm1", 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1'b1, 16);
    run("m5xm7", 32'hFFFF_FFFB, 32'hFFFF_FFF9,
        32'd35, 1'b0, 16);
    run("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF,
        32'h0000_0001, 1'b1, 16);

    start(32'd5, 32'd6);
    seen = 1'b0;
    repeat (7) begin
      if (bus.data_resultRDY) seen = 1'b1;
      @(posedge clock);
      #1;
    end
    if (bus.data_resultRDY) seen = 1'b1;
    start(32'hFFFF_FFFC, 32'd9);
    wait_rdy(lat, busy_n);
    check("abort_no_rdy", 64'(seen), 64'd0);
    check("abort_lat", 64'(lat), 64'd16);
    check("abort_res", 64'(bus.data_result),
          64'h0000_0000_FFFF_FFDC);
    check("abort_exc",
          64'(bus.data_exception), 64'd0);

    start(32'd7, 32'd5);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_rdy",
          64'(bus.data_resultRDY), 64'd0);
    check("mid_rst_res",
          64'(bus.data_result), 64'd0);
    check("mid_rst_exc",
          64'(bus.data_exception), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run("3x3", 32'd3, 32'd3, 32'd9, 1'b0, 16);

    run("0x123", 32'd0, 32'd123,
        32'd0, 1'b0, ZLAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/booth_mult_sequencer.md
Name: booth_mult_sequencer

Overview:
Iterative radix-4 Booth multiplier: the sequencing FSM, iteration counter and product register around the Booth recoder. It takes a start pulse from the execute stage and runs WIDTH/2 add/shift iterations. It then returns a WIDTH-bit signed result with an overflow flag and a one-cycle ready pulse. It sits beside the ALU and stalls the pipeline via busy.

Parameters:
WIDTH, 32, operand/result width; must be even and at least 4
ITERS, WIDTH/2, derived localparam (not overridable); Booth iterations per multiply

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
ctrl_MULT  in  1  start pulse; operands sampled on the same edge
data_operandA  in  WIDTH  multiplicand M, signed
data_operandB  in  WIDTH  multiplier Q, signed
data_result  out  WIDTH  low WIDTH bits of the product
data_exception  out  1  product does not fit in WIDTH signed bits
data_resultRDY  out  1  one-cycle pulse: result and exception valid
busy  out  1  high while state is RUN

Behaviour:
- States: IDLE, RUN, DONE. Reset puts the FSM in IDLE, clears count and the product register, and drives every output to 0.
- Product register P = {acc[WIDTH+1:0], q[WIDTH-1:0], q_m1}. acc is two bits wider so that ±2M fits.
- IDLE with ctrl_MULT=1 on an edge:
  - latch M, sign-extended to WIDTH+2
  - load acc=0, q=B, q_m1=0, count=0
  - go to RUN
- RUN, every edge:
  - Recode {q[1],q[0],q_m1}:
    - 000/111 -> +0
    - 001/010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101/110 -> -M
  - acc += op, modulo 2^(WIDTH+2).
  - Arithmetic right shift of the whole of P by 2, with acc MSB replicated.
  - count++.
  - When count reaches ITERS-1 on this edge, go to DONE.
- Latency: if ctrl_MULT is sampled at edge E0, iterations occur at E1..E_ITERS. data_resultRDY is high in the cycle after E_ITERS and is driven directly from state==DONE. For WIDTH=32 that is 16 edges after E0.
- DONE, for one cycle:
  - data_result = q, i.e. product[WIDTH-1:0]
  - data_exception = 1 when acc bits are not all equal to q[WIDTH-1]
  - next edge goes to IDLE
- data_result and data_exception are registered. They hold their values until the next DONE. They are not cleared on a new start.
- ctrl_MULT in RUN or DONE: abort the current multiply, reload the new operands and restart at count=0. No resultRDY is issued for the aborted operation.
- ctrl_MULT is level-sampled. If it is held high, the FSM restarts every edge and never completes; the issuer must pulse it.
- busy is combinational from state==RUN. It is 0 in IDLE and DONE.
- Reset asserted mid-operation: immediate return to IDLE, with no resultRDY pulse.
- Corner cases:
  - -2^(WIDTH-1) × -1 raises data_exception.
  - -2^(WIDTH-1) × 1 does not.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: in IDLE (or on a restart), if operand A==0 or B==0, go directly to DONE with P cleared. data_resultRDY then rises one cycle after the start edge, with result 0 and exception 0. busy never rises.
- Undefined: zero operands take the full ITERS iterations, with identical results.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE}
  - Booth op encoding {OP_NONE, OP_ADD_M, OP_ADD_2M, OP_SUB_M, OP_SUB_2M}
  - ITERS calculation function
  - localparam for the product-register width (2*WIDTH+3)
- One sub-module, booth_recode4: combinational 3-bit to op decoder.
- Counter, FSM and product register stay in the top level.

Test Plan:
- A=7, B=-3, pulse at E0 -> busy for 16 cycles; resultRDY only in cycle after E16; result=0xFFFFFFEB, exception=0.
- A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
- A=0x80000000 with B=1 -> result 0x80000000, exc 0; with B=-1 -> result 0x80000000, exc 1.
- Start A=5,B=6; at E8 pulse again with A=-4,B=9 -> single resultRDY at E8+16 with result=-36; no pulse for the first multiply.
- Reset asserted asynchronously mid-RUN (between edges) -> busy, resultRDY, result and exception read 0 immediately; a fresh start of 3×3 then gives 9.
- A=0, B=123 -> with MULT_ZERO_BYPASS_EN, resultRDY 1 cycle after start; without it, 16; result=0 either way.
